fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 32-bit PA-RISC pipeline, directly upstream of instruction_memory.
- Holds the architectural PC/nPC pair (PA-RISC delayed-branch model) and drives the 8-bit byte address to instruction memory.
- Captures the returned 32-bit word, plus its PC, into the IF/ID pipeline register.
- Supports hazard stall, branch redirect and delay-slot nullification.

Parameters:
- ADDR_W, 8: instruction byte-address width (256-byte memory).
- INST_W, 32: instruction width.
- RESET_PC, 0: PC value after reset; nPC resets to RESET_PC+4.
- NOP_INST, 32'h0800_0240: PA-RISC canonical NOP (OR r0,r0,r0), loaded into IF/ID on reset or nullify.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall; holds PC, nPC and IF/ID contents.
- branch_taken  in  1  redirect request from execute; sampled at the same edge as the PC update.
- branch_target  in  ADDR_W  redirect byte address; bits [1:0] ignored (treated as 00).
- nullify  in  1  squash the instruction currently being captured into IF/ID.
- imem_addr  out  ADDR_W  address to instruction memory, equal to PC (combinational from the register).
- imem_inst  in  INST_W  big-endian word returned combinationally by instruction memory.
- ifid_inst  out  INST_W  registered instruction for decode.
- ifid_pc  out  ADDR_W  PC of ifid_inst.
- ifid_valid  out  1  1 = ifid_inst is a real instruction; 0 = bubble/NOP.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-branch):
  - PC=RESET_PC, nPC=RESET_PC+4.
  - ifid_inst=NOP_INST, ifid_pc=0, ifid_valid=0.
  - imem_addr=RESET_PC immediately.
- Normal cycle (stall=0):
  - PC<=nPC.
  - nPC<= branch_taken ? {branch_target[7:2],2'b00} : nPC+4.
- Delayed branch:
  - The instruction at the old nPC (delay slot) is always fetched.
  - The target appears on imem_addr two edges after the branch_taken edge: edge 1 PC<=slot, edge 2 PC<=target.
- Arithmetic: nPC+4 is modulo 2^ADDR_W. 0xFC wraps to 0x00; no flag, no exception.
- IF/ID update when stall=0:
  - nullify=0: ifid_inst<=imem_inst, ifid_pc<=PC, ifid_valid<=1.
  - nullify=1: ifid_inst<=NOP_INST, ifid_pc<=PC, ifid_valid<=0.
- stall=1:
  - PC, nPC, ifid_pc and ifid_valid hold.
  - branch_taken is ignored; the requester must hold it until stall drops.
  - imem_addr stays constant, so the memory output is stable.
- stall=1 with nullify=1: nullify wins for IF/ID only (ifid_inst<=NOP_INST, ifid_valid<=0). PC and nPC still hold.
- branch_taken and nullify in the same cycle: both apply independently (redirect nPC, squash the captured word).
- Latency:
  - Address to IF/ID: 1 cycle.
  - Redirect to target in IF/ID: 3 edges after branch_taken (slot, target fetch, target capture).
- No X propagation: every output is defined from reset onward. Uninitialised memory words pass through unchanged.

Decomposition:
- Shared package pa_risc_pkg holds:
  - ADDR_W and INST_W.
  - NOP_INST.
  - The PC_INC=4 constant.
- One natural sub-module, pc_npc_reg:
  - Contains the PC/nPC registers, the +4 adder and the redirect mux with stall enable.
  - fetch_stage instantiates it and adds the IF/ID register and nullify logic.

Test Plan:
- Reset then 4 free-running cycles, memory word at n = n+0x100, stall=0 -> imem_addr 0,4,8,12; ifid_pc lags by one; ifid_valid=1 after the first edge; ifid_inst matches the word.
- branch_taken=1 with target 0x40 when PC=0x08 (nPC=0x0C) -> imem_addr sequence 0x0C, then 0x40, 0x44.
- Stall for 3 cycles at PC=0x10 -> imem_addr and IF/ID hold for exactly 3 cycles, then resume at 0x14.
- nullify=1 for one cycle while capturing PC 0x20 -> ifid_inst=0x08000240, ifid_valid=0, ifid_pc=0x20.
- Redirect to 0xFC, then run 2 cycles -> addresses 0xFC, 0x00, 0x04 (wrap).
- Assert reset mid-stall with branch_taken=1 and target 0x80 -> outputs return to reset values immediately, no redirect; fetch restarts at 0x00.

Source files
------------

// File: rtl/pa_risc_pkg.sv
// Shared PA-RISC fetch types and constants: address/instruction widths, canonical NOP, PC increment.
// Every file in the fetch slice imports this package.
package pa_risc_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam inst_t NOP_INST = 32'h0800_0240;
  localparam addr_t PC_INC   = 8'd4;

  // Instructions are word aligned; the low two address bits carry no meaning.
  function automatic addr_t word_align(input addr_t a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline control inputs, the instruction memory port and the IF/ID outputs.
// The master modport is the fetch stage; the slave modport is its surrounding pipeline and memory.
interface fetch_stage_if;
  import pa_risc_pkg::*;

  logic  stall;
  logic  branch_taken;
  addr_t branch_target;
  logic  nullify;
  addr_t imem_addr;
  inst_t imem_inst;
  inst_t ifid_inst;
  addr_t ifid_pc;
  logic  ifid_valid;

  modport master (
    input  stall, branch_taken, branch_target, nullify, imem_inst,
    output imem_addr, ifid_inst, ifid_pc, ifid_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, nullify, imem_inst,
    input  imem_addr, ifid_inst, ifid_pc, ifid_valid
  );

endinterface

// File: rtl/fetch_stage_pc_npc_reg.sv
// PC/nPC pair for the delayed-branch model; a redirect loads nPC, so the delay slot is always fetched.
// Both registers hold while en is low, and branch_taken is ignored in that case.
module pc_npc_reg import pa_risc_pkg::*; #(
  parameter addr_t RESET_PC = '0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  branch_taken,
  input  addr_t branch_target,
  output addr_t pc,
  output addr_t npc
);

  addr_t pc_q, pc_d;
  addr_t npc_q, npc_d;

  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    if (en) begin
      pc_d  = npc_q;
      // The +4 wraps modulo 2^ADDR_W with no overflow indication.
      npc_d = branch_taken ? word_align(branch_target) : npc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      npc_q <= RESET_PC + PC_INC;
    end else begin
      pc_q  <= pc_d;
      npc_q <= npc_d;
    end
  end

  assign pc  = pc_q;
  assign npc = npc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives PC to instruction memory and captures word plus PC into IF/ID one edge later.
// A stall freezes PC/nPC and IF/ID, but a nullify still squashes the IF/ID word to a NOP bubble.
module fetch_stage import pa_risc_pkg::*; #(
  parameter addr_t RESET_PC = '0
) (
  input logic            clk,
  input logic            reset,
  fetch_stage_if.master  bus
);

  addr_t pc;
  addr_t npc;

  pc_npc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_npc_reg (
    .clk           (clk),
    .reset         (reset),
    .en            (!bus.stall),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .pc            (pc),
    .npc           (npc)
  );

  assign bus.imem_addr = pc;

  inst_t ifid_inst_q, ifid_inst_d;
  addr_t ifid_pc_q, ifid_pc_d;
  logic  ifid_valid_q, ifid_valid_d;

  always_comb begin
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (!bus.stall) begin
      ifid_inst_d  = bus.imem_inst;
      ifid_pc_d    = pc;
      ifid_valid_d = 1'b1;
    end
    // Squash takes effect even under stall; ifid_pc keeps its held value then.
    if (bus.nullify) begin
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_inst_q  <= NOP_INST;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.ifid_inst  = ifid_inst_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, delayed branch, stall, nullify, wrap and reset mid-stall.
// Memory model returns 0x100 + byte address for every word.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0800_0240;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_stage_if fif ();

  fetch_stage #(.RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fif)
  );

  always #5 clk = ~clk;

  assign fif.imem_inst = 32'h100 + {24'h0, fif.imem_addr};

  function automatic logic [31:0] word(input logic [7:0] a);
    return 32'h100 + {24'h0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] addr, input logic [7:0] pc,
                         input logic [31:0] inst, input logic valid);
    chk({tag, ".imem_addr"},  {24'h0, fif.imem_addr}, {24'h0, addr});
    chk({tag, ".ifid_pc"},    {24'h0, fif.ifid_pc},   {24'h0, pc});
    chk({tag, ".ifid_inst"},  fif.ifid_inst,          inst);
    chk({tag, ".ifid_valid"}, {31'h0, fif.ifid_valid}, {31'h0, valid});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fif.stall         = 1'b0;
    fif.branch_taken  = 1'b0;
    fif.branch_target = 8'h00;
    fif.nullify       = 1'b0;
    step();
    step();
    chk_all("reset", 8'h00, 8'h00, NOP, 1'b0);
    reset = 1'b0;

    // Sequential fetch
    step(); chk_all("seq1", 8'h04, 8'h00, word(8'h00), 1'b1);
    step(); chk_all("seq2", 8'h08, 8'h04, word(8'h04), 1'b1);

    // Delayed branch to 0x40 (low bits of target ignored)
    fif.branch_taken = 1'b1; fif.branch_target = 8'h43;
    step(); chk_all("br_slot", 8'h0C, 8'h08, word(8'h08), 1'b1);
    fif.branch_taken = 1'b0;
    step(); chk_all("br_tgt", 8'h40, 8'h0C, word(8'h0C), 1'b1);
    step(); chk_all("br_cap", 8'h44, 8'h40, word(8'h40), 1'b1);

    // Redirect to 0x10 then stall 3 cycles
    fif.branch_taken = 1'b1; fif.branch_target = 8'h10;
    step(); chk_all("to10_slot", 8'h48, 8'h44, word(8'h44), 1'b1);
    fif.branch_taken = 1'b0;
    step(); chk_all("to10", 8'h10, 8'h48, word(8'h48), 1'b1);
    fif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all($sformatf("stall%0d", i), 8'h10, 8'h48, word(8'h48), 1'b1);
    end
    fif.stall = 1'b0;
    step(); chk_all("unstall", 8'h14, 8'h10, word(8'h10), 1'b1);

    // Redirect to 0x20 and nullify its capture
    fif.branch_taken = 1'b1; fif.branch_target = 8'h20;
    step(); chk_all("to20_slot", 8'h18, 8'h14, word(8'h14), 1'b1);
    fif.branch_taken = 1'b0;
    step(); chk_all("to20", 8'h20, 8'h18, word(8'h18), 1'b1);
    fif.nullify = 1'b1;
    step(); chk_all("nullify", 8'h24, 8'h20, NOP, 1'b0);
    fif.nullify = 1'b0;
    step(); chk_all("post_null", 8'h28, 8'h24, word(8'h24), 1'b1);

    // Stall together with nullify: IF/ID squashed, PC and ifid_pc hold
    fif.stall = 1'b1; fif.nullify = 1'b1;
    step(); chk_all("stall_null", 8'h28, 8'h24, NOP, 1'b0);
    fif.stall = 1'b0; fif.nullify = 1'b0;
    step(); chk_all("post_sn", 8'h2C, 8'h28, word(8'h28), 1'b1);

    // Redirect to 0xFC and wrap
    fif.branch_taken = 1'b1; fif.branch_target = 8'hFC;
    step(); chk_all("toFC_slot", 8'h30, 8'h2C, word(8'h2C), 1'b1);
    fif.branch_taken = 1'b0;
    step(); chk_all("toFC", 8'hFC, 8'h30, word(8'h30), 1'b1);
    step(); chk_all("wrap0", 8'h00, 8'hFC, word(8'hFC), 1'b1);
    step(); chk_all("wrap4", 8'h04, 8'h00, word(8'h00), 1'b1);

    // Branch and nullify in the same cycle
    fif.branch_taken = 1'b1; fif.branch_target = 8'h10; fif.nullify = 1'b1;
    step(); chk_all("brnull_slot", 8'h08, 8'h04, NOP, 1'b0);
    fif.branch_taken = 1'b0; fif.nullify = 1'b0;
    step(); chk_all("brnull_tgt", 8'h10, 8'h08, word(8'h08), 1'b1);

    // Reset asserted mid-stall with a pending redirect
    fif.stall = 1'b1; fif.branch_taken = 1'b1; fif.branch_target = 8'h80;
    step(); chk_all("pre_rst", 8'h10, 8'h08, word(8'h08), 1'b1);
    #2 reset = 1'b1;
    #1 chk_all("async_rst", 8'h00, 8'h00, NOP, 1'b0);
    step(); chk_all("rst_held", 8'h00, 8'h00, NOP, 1'b0);
    fif.stall = 1'b0; fif.branch_taken = 1'b0;
    reset = 1'b0;
    step(); chk_all("restart1", 8'h04, 8'h00, word(8'h00), 1'b1);
    step(); chk_all("restart2", 8'h08, 8'h04, word(8'h04), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
